// File: rtl/cache_bus_pkg.sv
// Shared types for the data-cache bus arbiter: FSM states, owner ids and size codes.
package cache_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;

endpackage

// File: rtl/bus_arb_prio.sv
// D-over-I priority arbiter with a starvation guard that forces an I win
// after STARVE_LIMIT consecutive D wins while I was waiting.
module bus_arb_prio
  import cache_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   arb_en_i,
  input  logic   i_req_i,
  input  logic   d_req_i,
  output logic   grant_o,
  output owner_e winner_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;

  always_comb begin
    grant_o  = i_req_i | d_req_i;
    winner_o = OWN_D;
    if (i_req_i && (!d_req_i || starve_q == LIMIT)) begin
      winner_o = OWN_I;
    end
  end

  // Only arbitration cycles move the counter; an idle I clears the streak.
  always_comb begin
    starve_d = starve_q;
    if (arb_en_i) begin
      if (!i_req_i || winner_o == OWN_I) begin
        starve_d = '0;
      end else if (starve_q != LIMIT) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/dcache_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch (read-only) and the
// MEM-stage data port; one transaction in flight, request fields latched at grant.
module dcache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [2:0]          d_size,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_wr,
  output logic [2:0]          m_size,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata
);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  m_wr_q, m_wr_d;
  logic [2:0]            m_size_q, m_size_d;
  logic [DATA_W/8-1:0]   m_wstrb_q, m_wstrb_d;
  logic [ADDR_W-1:0]     m_addr_q, m_addr_d;
  logic [DATA_W-1:0]     m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0]     i_rdata_q, d_rdata_q;
  logic                  grant, take, done;
  owner_e                winner;

  bus_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk     (clk),
    .resetn  (resetn),
    .arb_en_i(state_q == ST_IDLE),
    .i_req_i (i_req),
    .d_req_i (d_req),
    .grant_o (grant),
    .winner_o(winner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_wr_d    = m_wr_q;
    m_size_d  = m_size_q;
    m_wstrb_d = m_wstrb_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    take      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          take    = 1'b1;
          state_d = ST_ADDR;
          owner_d = winner;
          if (winner == OWN_I) begin
            m_wr_d    = 1'b0;
            m_size_d  = SZ_W;
            m_wstrb_d = '0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
          end else begin
            m_wr_d    = d_wr;
            m_size_d  = d_size;
            m_wstrb_d = d_wr ? d_wstrb : '0;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
          end
        end
      end
      // A lone m_data_ok here is a downstream protocol error and is dropped.
      ST_ADDR: begin
        if (m_addr_ok) begin
          done    = m_data_ok;
          state_d = m_data_ok ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (m_data_ok) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // addr_ok is gated by resetn so no grant pulse leaks out while reset is held.
  assign i_addr_ok = resetn & take & (winner == OWN_I);
  assign d_addr_ok = resetn & take & (winner == OWN_D);
  assign i_data_ok = done & (owner_q == OWN_I);
  assign d_data_ok = done & (owner_q == OWN_D);
  assign i_rdata   = i_data_ok ? m_rdata : i_rdata_q;
  assign d_rdata   = d_data_ok ? m_rdata : d_rdata_q;
  assign m_req     = (state_q == ST_ADDR);
  assign m_wr      = m_wr_q;
  assign m_size    = m_size_q;
  assign m_wstrb   = m_wstrb_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_D;
      m_wr_q    <= 1'b0;
      m_size_q  <= '0;
      m_wstrb_q <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_wr_q    <= m_wr_d;
      m_size_q  <= m_size_d;
      m_wstrb_q <= m_wstrb_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata;
      d_rdata_q <= d_rdata;
    end
  end

endmodule
